// File: rtl/pc_stack_unit_if.sv
// Command/status bundle between fetch control and the program counter.
// The master drives PC commands, and the slave returns the registered PC and its status.
interface pc_stack_unit_if #(
  parameter int ADDR_W = 11
) ();
  logic              inc;
  logic              branch_en;
  logic              call_en;
  logic              ret_en;
  logic              halt;
  logic              resume;
  logic              clr_fault;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] current_addr;
  logic              halted;
  logic              fault;
  logic [1:0]        fault_code;
  logic              stack_empty;
  logic              stack_full;

  modport master (
    output inc, branch_en, call_en, ret_en, halt, resume, clr_fault, branch_addr,
    input  current_addr, halted, fault, fault_code, stack_empty, stack_full
  );

  modport slave (
    input  inc, branch_en, call_en, ret_en, halt, resume, clr_fault, branch_addr,
    output current_addr, halted, fault, fault_code, stack_empty, stack_full
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a return-address stack, a sticky halt and a fault trap for stack misuse.
// A command sampled at edge N is visible after edge N. There is no backpressure: commands are taken every cycle.
module pc_stack_unit #(
  parameter int                ADDR_W      = 11,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_stack_unit_if.slave     bus
);

  localparam int             SP_W    = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_OVERFLOW  = 2'b01;
  localparam logic [1:0] FC_UNDERFLOW = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stack_top;
  logic              push;
  logic              is_empty;
  logic              is_full;

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == SP_FULL);

  // Entry sp-1 holds the most recent return address.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) begin
        stack_top = stack_q[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    sp_d         = sp_q;
    fault_code_d = fault_code_q;
    push         = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.halt) begin
          state_d = ST_HALT;
        end else if (bus.ret_en) begin
          if (is_empty) begin
            state_d      = ST_FAULT;
            fault_code_d = FC_UNDERFLOW;
          end else begin
            pc_d = stack_top;
            sp_d = sp_q - SP_W'(1);
          end
        end else if (bus.call_en) begin
          if (is_full) begin
            state_d      = ST_FAULT;
            fault_code_d = FC_OVERFLOW;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
            pc_d = bus.branch_addr;
          end
        end else if (bus.branch_en) begin
          pc_d = bus.branch_addr;
        end else if (bus.inc) begin
          pc_d = pc_inc;
        end
      end

      ST_HALT: begin
        // A simultaneous halt keeps the unit parked, and the resume cycle itself moves nothing.
        if (bus.resume && !bus.halt) begin
          state_d = ST_RUN;
        end
      end

      ST_FAULT: begin
        if (bus.clr_fault) begin
          state_d      = ST_RUN;
          pc_d         = RESET_ADDR;
          sp_d         = '0;
          fault_code_d = FC_NONE;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    stack_d = stack_q;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && (sp_q == SP_W'(i))) begin
        stack_d[i] = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_ADDR;
      sp_q         <= '0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      sp_q         <= sp_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Contents are don't-care after reset, but clearing them keeps a push in flight from landing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      stack_q <= stack_d;
    end
  end

  assign bus.current_addr = pc_q;
  assign bus.halted       = (state_q == ST_HALT);
  assign bus.fault        = (state_q == ST_FAULT);
  assign bus.fault_code   = fault_code_q;
  assign bus.stack_empty  = is_empty;
  assign bus.stack_full   = is_full;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed and random bench for pc_stack_unit, checked against a queue-based reference model.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_pc_stack_unit;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 4;
  localparam int MODULO = 1 << ADDR_W;

  logic clk;
  logic rst_n;

  pc_stack_unit_if #(.ADDR_W(ADDR_W)) bus ();

  pc_stack_unit #(
    .ADDR_W(ADDR_W),
    .STACK_DEPTH(DEPTH),
    .RESET_ADDR('0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_pass;

  // Reference model
  int m_pc;
  int m_stk[$];
  bit m_halted;
  bit m_fault;
  int m_code;

  task automatic model_reset();
    m_pc     = 0;
    m_stk.delete();
    m_halted = 1'b0;
    m_fault  = 1'b0;
    m_code   = 0;
  endtask

  task automatic model_step(input bit i, input bit b, input bit c, input bit r,
                            input bit h, input bit rs, input bit cf, input int ba);
    if (m_fault) begin
      if (cf) begin
        m_fault = 1'b0;
        m_pc    = 0;
        m_code  = 0;
        m_stk.delete();
      end
    end else if (m_halted) begin
      if (rs && !h) m_halted = 1'b0;
    end else if (h) begin
      m_halted = 1'b1;
    end else if (r) begin
      if (m_stk.size() == 0) begin
        m_fault = 1'b1;
        m_code  = 2;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (c) begin
      if (m_stk.size() == DEPTH) begin
        m_fault = 1'b1;
        m_code  = 1;
      end else begin
        m_stk.push_back((m_pc + 1) % MODULO);
        m_pc = ba;
      end
    end else if (b) begin
      m_pc = ba;
    end else if (i) begin
      m_pc = (m_pc + 1) % MODULO;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},     32'(bus.current_addr), 32'(m_pc));
    chk({tag, ".halted"}, 32'(bus.halted),       32'(m_halted));
    chk({tag, ".fault"},  32'(bus.fault),        32'(m_fault));
    chk({tag, ".code"},   32'(bus.fault_code),   32'(m_code));
    chk({tag, ".empty"},  32'(bus.stack_empty),  32'(m_stk.size() == 0));
    chk({tag, ".full"},   32'(bus.stack_full),   32'(m_stk.size() == DEPTH));
  endtask

  task automatic cyc(input string tag, input bit i, input bit b, input bit c, input bit r,
                     input bit h, input bit rs, input bit cf, input int ba);
    bus.inc         = i;
    bus.branch_en   = b;
    bus.call_en     = c;
    bus.ret_en      = r;
    bus.halt        = h;
    bus.resume      = rs;
    bus.clr_fault   = cf;
    bus.branch_addr = ADDR_W'(ba);
    @(posedge clk);
    model_step(i, b, c, r, h, rs, cf, ba);
    #1;
    chk_model(tag);
  endtask

  //                     tag  inc br call ret halt res clr addr
  task automatic do_inc(input string tag);    cyc(tag, 1, 0, 0, 0, 0, 0, 0, 0);  endtask
  task automatic do_br(input string tag, input int a);   cyc(tag, 0, 1, 0, 0, 0, 0, 0, a); endtask
  task automatic do_call(input string tag, input int a); cyc(tag, 0, 0, 1, 0, 0, 0, 0, a); endtask
  task automatic do_ret(input string tag);    cyc(tag, 0, 0, 0, 1, 0, 0, 0, 0);  endtask
  task automatic do_clr(input string tag);    cyc(tag, 0, 0, 0, 0, 0, 0, 1, 0);  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    bus.inc = 0; bus.branch_en = 0; bus.call_en = 0; bus.ret_en = 0;
    bus.halt = 0; bus.resume = 0; bus.clr_fault = 0; bus.branch_addr = '0;
    model_reset();

    // 1. Reset then increment
    rst_n = 1'b0;
    bus.inc = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_model("reset");
    chk("reset.pc_const", 32'(bus.current_addr), 32'h0);
    rst_n = 1'b1;
    do_inc("inc1"); chk("inc1.const", 32'(bus.current_addr), 32'd1);
    do_inc("inc2"); chk("inc2.const", 32'(bus.current_addr), 32'd2);
    do_inc("inc3"); chk("inc3.const", 32'(bus.current_addr), 32'd3);

    // 2. Wrap at the top of the address space
    do_br("wrap_br", 'h7FF); chk("wrap_br.const", 32'(bus.current_addr), 32'h7FF);
    do_inc("wrap_inc");      chk("wrap_inc.const", 32'(bus.current_addr), 32'h000);

    // 3. Call / return
    do_br("cr_br", 'h010);
    do_call("cr_call", 'h100);
    chk("cr_call.const", 32'(bus.current_addr), 32'h100);
    chk("cr_call.empty", 32'(bus.stack_empty), 32'd0);
    do_inc("cr_inc1");
    do_inc("cr_inc2"); chk("cr_inc2.const", 32'(bus.current_addr), 32'h102);
    do_ret("cr_ret");
    chk("cr_ret.const", 32'(bus.current_addr), 32'h011);
    chk("cr_ret.empty", 32'(bus.stack_empty), 32'd1);

    // 4. Overflow
    for (int k = 0; k < DEPTH; k++) do_call("ov_call", 'h200 + k * 'h10);
    chk("ov_full.const", 32'(bus.stack_full), 32'd1);
    do_call("ov_5th", 'h555);
    chk("ov_5th.pc", 32'(bus.current_addr), 32'h230);
    chk("ov_5th.fault", 32'(bus.fault), 32'd1);
    chk("ov_5th.code", 32'(bus.fault_code), 32'b01);
    do_inc("ov_inc_ignored");
    chk("ov_inc.pc", 32'(bus.current_addr), 32'h230);
    do_clr("ov_clr");
    chk("ov_clr.pc", 32'(bus.current_addr), 32'h0);
    chk("ov_clr.fault", 32'(bus.fault), 32'd0);
    chk("ov_clr.empty", 32'(bus.stack_empty), 32'd1);

    // 5. Underflow and command priority
    do_ret("un_ret");
    chk("un_ret.code", 32'(bus.fault_code), 32'b10);
    do_clr("un_clr");
    do_call("pr_call", 'h300);
    cyc("pr_multi", 1, 0, 1, 1, 0, 0, 0, 'h444);
    chk("pr_multi.pc", 32'(bus.current_addr), 32'h001);
    chk("pr_multi.empty", 32'(bus.stack_empty), 32'd1);

    // 6. Halt / resume / async reset while halted
    do_br("h_br", 'h005);
    cyc("h_halt", 1, 0, 0, 0, 1, 0, 0, 0);
    chk("h_halt.pc", 32'(bus.current_addr), 32'h005);
    chk("h_halt.halted", 32'(bus.halted), 32'd1);
    cyc("h_both", 1, 0, 0, 0, 1, 1, 0, 0);
    chk("h_both.halted", 32'(bus.halted), 32'd1);
    cyc("h_resume", 1, 0, 0, 0, 0, 1, 0, 0);
    chk("h_resume.halted", 32'(bus.halted), 32'd0);
    chk("h_resume.pc", 32'(bus.current_addr), 32'h005);
    do_inc("h_after"); chk("h_after.pc", 32'(bus.current_addr), 32'h006);
    cyc("h_again", 0, 0, 0, 0, 1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_model("h_async_rst");
    chk("h_async_rst.pc", 32'(bus.current_addr), 32'h0);
    chk("h_async_rst.halted", 32'(bus.halted), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cyc("rand",
          $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 30,
          int'($urandom_range(0, MODULO - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
